branch_seq: RTL and testbench
=============================

Name: branch_seq

Overview:
- Control-side sequencer that drives the branch condition flip-flop from the other end of its interface.
- On a decoded conditional-branch instruction it:
  - gates the condition register onto the bus;
  - issues a clean rising edge on CON_enable while the bus is stable;
  - samples the latched condition result;
  - if taken, gates the target register onto the bus and loads PC.
- Sits beside the main control unit and owns the bus-control strobes only while busy.
- Also keeps a saturating taken-branch counter for debug.

Parameters:
- CNT_BITS, 16, width of the taken-branch counter.
- SETTLE, 1, extra bus-settle cycles after the source register is driven, before CON_enable rises (0..3).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; IR holds a branch opcode with the C2 field valid.
- con_q  input  1  Q output of the condition flip-flop.
- Gra  output  1  select the IR ra field as register source (condition register).
- Grb  output  1  select the IR rb field as register source (target register).
- Rout  output  1  drive the selected register onto the bus.
- CON_enable  output  1  latch strobe to the condition flip-flop; the rising edge samples.
- PCin  output  1  load PC from the bus.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at sequence end.
- taken  output  1  valid with done; 1 means PC was loaded.
- taken_cnt  output  CNT_BITS  saturating count of taken branches.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE.
  - All strobes, busy, done and taken are 0.
  - taken_cnt=0.
  - Asserting reset mid-sequence aborts immediately; strobes drop asynchronously.
- All outputs are registered. Strobes are decoded from the state register, so they are glitch-free.
- States and transitions:
  - IDLE: all strobes 0. If start=1, go to DRIVE and load settle counter=SETTLE.
  - DRIVE: Gra=1, Rout=1. If settle counter=0, go to LATCH; else decrement.
  - LATCH: Gra=1, Rout=1, CON_enable=1. The bus stays driven for this whole cycle, so the flip-flop captures stable data on the CON_enable rising edge. Go to SAMPLE.
  - SAMPLE: all strobes 0; con_q is now settled.
    - con_q=1 -> TAKE.
    - con_q=0 -> FIN with taken_r=0.
  - TAKE: Grb=1, Rout=1, PCin=1 for exactly one cycle. Go to FIN with taken_r=1.
  - FIN: done=1, taken=taken_r. If taken_r=1 and taken_cnt is not all ones, increment taken_cnt. Go to IDLE.
- Cycle counts from the start cycle to done (SETTLE=0):
  - not taken: 4 cycles;
  - taken: 5 cycles;
  - each SETTLE unit adds 1 cycle.
- Strobe exclusivity:
  - CON_enable is high for exactly one cycle per branch, and never in consecutive branches without a low cycle between.
  - Gra and Grb are never high together.
  - PCin is never high unless con_q was 1 in SAMPLE.
- Start handling:
  - start while busy=1 or during FIN is ignored (not queued).
  - start in the same cycle as a FIN->IDLE transition is ignored.
  - start in IDLE is accepted.
- taken_cnt saturates at 2^CNT_BITS-1 and does not wrap.

Optional Feature:
- Macro: BRANCH_SEQ_LINK_EN.
- When defined:
  - Adds input link (1 = brl-type instruction, sampled with start) and outputs PCout and Grc.
  - For a link branch, a LINK state is inserted between SAMPLE and TAKE/FIN; it is entered regardless of con_q.
  - LINK drives PCout=1, Grc=1 and a new output Rin=1 for one cycle, saving the return address into rc.
  - Link latency is +1 cycle.
- When undefined: no link, PCout, Grc or Rin ports; link behaviour is absent.

Test Plan:
- Reset then start with con_q tied to 1, SETTLE=0 -> sequence DRIVE, LATCH, SAMPLE, TAKE, FIN; PCin high exactly in cycle 4; done/taken=1 in cycle 5; taken_cnt=1.
- start with con_q=0 -> no PCin; done with taken=0 at cycle 4; taken_cnt unchanged.
- SETTLE=2, taken branch -> Gra/Rout high 2 extra cycles before CON_enable; done at cycle 7.
- start pulsed during TAKE and during FIN -> ignored; exactly one done; busy never deasserts early.
- clr asserted during LATCH -> all strobes 0 immediately; after release, state IDLE and taken_cnt=0.
- CNT_BITS=2, run 5 taken branches -> taken_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/branch_seq.sv
`default_nettype none
// ============================================================================
// Module      : branch_seq
// Description : Conditional-branch sequencer. It drives the condition register
//               onto the bus, strobes CON_enable, samples con_q and, when the
//               branch is taken, loads PC from the target register.
//               Optional macro BRANCH_SEQ_LINK_EN adds the brl link step.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_seq #(
    parameter int CNT_BITS = 16,
    parameter int SETTLE   = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
`ifdef BRANCH_SEQ_LINK_EN
    input  logic                link,
    output logic                PCout,
    output logic                Grc,
    output logic                Rin,
`endif
    input  logic                con_q,
    output logic                Gra,
    output logic                Grb,
    output logic                Rout,
    output logic                CON_enable,
    output logic                PCin,
    output logic                busy,
    output logic                done,
    output logic                taken,
    output logic [CNT_BITS-1:0] taken_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_TAKE   = 3'd4,
        ST_FIN    = 3'd5
`ifdef BRANCH_SEQ_LINK_EN
        , ST_LINK = 3'd6
`endif
    } state_t;

    localparam logic [1:0]          c_settle  = 2'(SETTLE);
    localparam logic [CNT_BITS-1:0] c_cnt_max = {CNT_BITS{1'b1}};

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_settle;
    logic [1:0]          w_settle_next;
    logic                r_taken;
    logic                w_taken_next;
    logic [CNT_BITS-1:0] r_cnt;

    logic r_gra, r_grb, r_rout, r_con_en, r_pcin, r_busy, r_done, r_taken_o;
    logic w_gra, w_grb, w_rout, w_con_en, w_pcin, w_busy, w_done, w_taken_o;

`ifdef BRANCH_SEQ_LINK_EN
    logic r_link;
    logic w_link_next;
    logic r_link_strb;
    logic w_link_strb;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        w_taken_next  = r_taken;
`ifdef BRANCH_SEQ_LINK_EN
        w_link_next   = r_link;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next  = ST_DRIVE;
                    w_settle_next = c_settle;
                    w_taken_next  = 1'b0;
`ifdef BRANCH_SEQ_LINK_EN
                    w_link_next   = link;
`endif
                end
            end
            ST_DRIVE: begin
                if (r_settle == 2'd0) begin
                    w_state_next = ST_LATCH;
                end else begin
                    w_settle_next = r_settle - 2'd1;
                end
            end
            ST_LATCH: w_state_next = ST_SAMPLE;
            ST_SAMPLE: begin
                // The condition result is remembered so a link step can sit in between.
                w_taken_next = con_q;
`ifdef BRANCH_SEQ_LINK_EN
                if (r_link) begin
                    w_state_next = ST_LINK;
                end else
`endif
                w_state_next = con_q ? ST_TAKE : ST_FIN;
            end
`ifdef BRANCH_SEQ_LINK_EN
            ST_LINK: w_state_next = r_taken ? ST_TAKE : ST_FIN;
`endif
            ST_TAKE: w_state_next = ST_FIN;
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        w_gra     = (w_state_next == ST_DRIVE) || (w_state_next == ST_LATCH);
        w_grb     = (w_state_next == ST_TAKE);
        w_rout    = w_gra || w_grb;
        w_con_en  = (w_state_next == ST_LATCH);
        w_pcin    = (w_state_next == ST_TAKE);
        w_busy    = (w_state_next != ST_IDLE) && (w_state_next != ST_FIN);
        w_done    = (w_state_next == ST_FIN);
        w_taken_o = (w_state_next == ST_FIN) && w_taken_next;
`ifdef BRANCH_SEQ_LINK_EN
        w_link_strb = (w_state_next == ST_LINK);
`endif
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= ST_IDLE;
            r_settle  <= 2'd0;
            r_taken   <= 1'b0;
            r_cnt     <= '0;
            r_gra     <= 1'b0;
            r_grb     <= 1'b0;
            r_rout    <= 1'b0;
            r_con_en  <= 1'b0;
            r_pcin    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_taken_o <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_settle  <= w_settle_next;
            r_taken   <= w_taken_next;
            r_gra     <= w_gra;
            r_grb     <= w_grb;
            r_rout    <= w_rout;
            r_con_en  <= w_con_en;
            r_pcin    <= w_pcin;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_taken_o <= w_taken_o;
            if (r_state == ST_FIN && r_taken && r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + CNT_BITS'(1);
            end
        end
    end

`ifdef BRANCH_SEQ_LINK_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_link      <= 1'b0;
            r_link_strb <= 1'b0;
        end else begin
            r_link      <= w_link_next;
            r_link_strb <= w_link_strb;
        end
    end

    assign PCout = r_link_strb;
    assign Grc   = r_link_strb;
    assign Rin   = r_link_strb;
`endif

    assign Gra        = r_gra;
    assign Grb        = r_grb;
    assign Rout       = r_rout;
    assign CON_enable = r_con_en;
    assign PCin       = r_pcin;
    assign busy       = r_busy;
    assign done       = r_done;
    assign taken      = r_taken_o;
    assign taken_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_seq
// Description : Directed self-checking bench for branch_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        con_q;
    logic [2:0]  start;
    logic [2:0]  gra, grb, rout, con_en, pcin, busy, done, taken;
    logic [15:0] cnt0, cnt2;
    logic [1:0]  cnt_sat;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_done;
    logic [7:0]  exp_tab [0:11];
    logic [1:0]  exp_sat [0:4];

    always #5 clk = ~clk;

    branch_seq #(.CNT_BITS(16), .SETTLE(0)) u_dut0 (
        .clk(clk), .clr(clr), .start(start[0]), .con_q(con_q),
        .Gra(gra[0]), .Grb(grb[0]), .Rout(rout[0]), .CON_enable(con_en[0]),
        .PCin(pcin[0]), .busy(busy[0]), .done(done[0]), .taken(taken[0]),
        .taken_cnt(cnt0)
    );

    branch_seq #(.CNT_BITS(16), .SETTLE(2)) u_dut2 (
        .clk(clk), .clr(clr), .start(start[1]), .con_q(con_q),
        .Gra(gra[1]), .Grb(grb[1]), .Rout(rout[1]), .CON_enable(con_en[1]),
        .PCin(pcin[1]), .busy(busy[1]), .done(done[1]), .taken(taken[1]),
        .taken_cnt(cnt2)
    );

    branch_seq #(.CNT_BITS(2), .SETTLE(0)) u_dut_sat (
        .clk(clk), .clr(clr), .start(start[2]), .con_q(con_q),
        .Gra(gra[2]), .Grb(grb[2]), .Rout(rout[2]), .CON_enable(con_en[2]),
        .PCin(pcin[2]), .busy(busy[2]), .done(done[2]), .taken(taken[2]),
        .taken_cnt(cnt_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // {Gra, Grb, Rout, CON_enable, PCin, busy, done, taken}
    function automatic logic [7:0] strobes(input int sel);
        return {gra[sel], grb[sel], rout[sel], con_en[sel], pcin[sel], busy[sel], done[sel], taken[sel]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycle i (1-based) is the i-th cycle after the accepted start edge.
    task automatic run_seq(input int sel, input string name, input int n, input logic [11:0] pulse);
        start[sel] = 1'b1;
        tick();
        n_done = 0;
        for (int i = 1; i <= n; i++) begin
            start[sel] = pulse[i];
            chk($sformatf("%s c%0d", name, i), 32'(strobes(sel)), 32'(exp_tab[i-1]));
            if (done[sel]) n_done++;
            tick();
        end
        start[sel] = 1'b0;
    endtask

    initial begin
        clr   = 1'b0;
        con_q = 1'b0;
        start = 3'b000;
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        tick();
        tick();
        for (int s = 0; s < 3; s++) chk($sformatf("reset strobes %0d", s), 32'(strobes(s)), 32'd0);
        chk("reset cnt0", 32'(cnt0), 32'd0);
        chk("reset cnt_sat", 32'(cnt_sat), 32'd0);
        clr = 1'b1;
        tick();

        // Taken branch, SETTLE=0
        con_q = 1'b1;
        exp_tab = '{8'hA4, 8'hB4, 8'h04, 8'h6C, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq(0, "taken", 7, 12'h000);
        chk("taken dones", 32'(n_done), 32'd1);
        chk("taken cnt", 32'(cnt0), 32'd1);

        // Not taken branch
        con_q = 1'b0;
        exp_tab = '{8'hA4, 8'hB4, 8'h04, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq(0, "ntaken", 6, 12'h000);
        chk("ntaken cnt", 32'(cnt0), 32'd1);

        // SETTLE=2, taken
        con_q = 1'b1;
        exp_tab = '{8'hA4, 8'hA4, 8'hA4, 8'hB4, 8'h04, 8'h6C, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq(1, "settle2", 8, 12'h000);
        chk("settle2 dones", 32'(n_done), 32'd1);
        chk("settle2 cnt", 32'(cnt2), 32'd1);

        // start pulsed during TAKE (c4) and FIN (c5) must be ignored
        exp_tab = '{8'hA4, 8'hB4, 8'h04, 8'h6C, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq(0, "ignore", 8, 12'h030);
        chk("ignore dones", 32'(n_done), 32'd1);
        chk("ignore cnt", 32'(cnt0), 32'd2);

        // Asynchronous reset while in LATCH
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("abort drive", 32'(strobes(0)), 32'hA4);
        tick();
        chk("abort latch", 32'(strobes(0)), 32'hB4);
        #2 clr = 1'b0;
        #1;
        chk("abort strobes", 32'(strobes(0)), 32'd0);
        chk("abort cnt", 32'(cnt0), 32'd0);
        clr = 1'b1;
        tick();
        chk("abort idle", 32'(strobes(0)), 32'd0);
        tick();
        chk("abort no restart", 32'(strobes(0)), 32'd0);
        exp_tab = '{8'hA4, 8'hB4, 8'h04, 8'h6C, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq(0, "post", 6, 12'h000);
        chk("post cnt", 32'(cnt0), 32'd1);

        // Saturation with CNT_BITS=2
        for (int k = 0; k < 5; k++) begin
            run_seq(2, $sformatf("sat%0d", k), 6, 12'h000);
            chk($sformatf("sat cnt %0d", k), 32'(cnt_sat), 32'(exp_sat[k]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
